// File: rtl/scope_dma_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : scope_dma_packetizer
//  Purpose  : Buffers scope samples and emits fixed-length tlast-framed DMA
//             packets, holding off between packets until the PS signals done.
//  Options  : define SCOPE_OVERFLOW_COUNT_EN to implement the drop counter.
//  Revision : 1.0 - initial release
// ============================================================================
module scope_dma_packetizer #(
    parameter int DATA_WIDTH    = 32,
    parameter int PACKET_LENGTH = 1024,
    parameter int FIFO_DEPTH    = 2048
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in_data,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out_data,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_tlast,
    input  logic                  dma_done,
    output logic                  busy,
    output logic [31:0]           overflow_count
);

    localparam int ADDR_WIDTH     = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH      = ADDR_WIDTH + 1;
    localparam int WORD_CNT_WIDTH = $clog2(PACKET_LENGTH + 1);

    localparam logic [CNT_WIDTH-1:0]      FIFO_FULL_LEVEL = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]      PACKET_LEVEL    = CNT_WIDTH'(PACKET_LENGTH);
    localparam logic [WORD_CNT_WIDTH-1:0] PACKET_WORDS    = WORD_CNT_WIDTH'(PACKET_LENGTH);
    localparam logic [WORD_CNT_WIDTH-1:0] LAST_WORD       = WORD_CNT_WIDTH'(PACKET_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_DMA = 2'd2
    } state_t;

    state_t                    state_q,    state_d;
    logic [ADDR_WIDTH-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [ADDR_WIDTH-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [CNT_WIDTH-1:0]      count_q,    count_d;
    logic [WORD_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q,  out_last_d;

    logic [DATA_WIDTH-1:0]     fifo_mem_q [FIFO_DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic wr_en;
    logic rd_en;
    logic out_fire;

    assign fifo_full  = (count_q == FIFO_FULL_LEVEL);
    assign fifo_empty = (count_q == '0);
    assign wr_en      = enable & data_in_valid & ~fifo_full;
    assign out_fire   = out_valid_q & data_out_ready;

    // The output register is refilled whenever it is empty or being drained,
    // which keeps valid continuously high across a packet with ready held.
    assign rd_en = (state_q == ST_SEND) && (word_cnt_q != PACKET_WORDS) &&
                   !fifo_empty && (!out_valid_q || data_out_ready);

    assign data_in_ready  = reset & (~enable | ~fifo_full);
    assign data_out_data  = out_data_q;
    assign data_out_valid = out_valid_q;
    assign data_out_tlast = out_last_q;
    assign busy           = (state_q != ST_IDLE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (rd_en) begin
            out_data_d  = fifo_mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
            out_last_d  = (word_cnt_q == LAST_WORD);
            word_cnt_d  = word_cnt_q + 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (count_q >= PACKET_LEVEL) begin
                    state_d    = ST_SEND;
                    word_cnt_d = '0;
                end
            end
            ST_SEND: begin
                if (out_fire && out_last_q) begin
                    state_d = ST_WAIT_DMA;
                end
            end
            ST_WAIT_DMA: begin
                if (dma_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            word_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            word_cnt_q  <= word_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            fifo_mem_q[wr_ptr_q] <= data_in_data;
        end
    end

`ifdef SCOPE_OVERFLOW_COUNT_EN
    logic [31:0] overflow_q, overflow_d;
    logic        sample_drop;

    assign sample_drop = enable & data_in_valid & fifo_full;

    always_comb begin
        overflow_d = overflow_q;
        if (sample_drop && (overflow_q != 32'hFFFF_FFFF)) begin
            overflow_d = overflow_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_count = overflow_q;
`else
    assign overflow_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scope_dma_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scope_dma_packetizer
//  Purpose  : Scoreboard bench for scope_dma_packetizer (PACKET_LENGTH=8,
//             FIFO_DEPTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scope_dma_packetizer;

    localparam int DW = 32;
    localparam int PL = 8;
    localparam int FD = 16;

`ifdef SCOPE_OVERFLOW_COUNT_EN
    localparam logic [31:0] EXP_OVF = 32'd5;
`else
    localparam logic [31:0] EXP_OVF = 32'd0;
`endif

    logic          clock          = 1'b0;
    logic          reset          = 1'b0;
    logic          enable         = 1'b0;
    logic [DW-1:0] data_in_data   = '0;
    logic          data_in_valid  = 1'b0;
    logic          data_in_ready;
    logic [DW-1:0] data_out_data;
    logic          data_out_valid;
    logic          data_out_ready = 1'b0;
    logic          data_out_tlast;
    logic          dma_done       = 1'b0;
    logic          busy;
    logic [31:0]   overflow_count;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] sb [$];
    int            out_idx  = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_data  = '0;
    logic          held_last  = 1'b0;
    int            pkt_len;

    scope_dma_packetizer #(
        .DATA_WIDTH    (DW),
        .PACKET_LENGTH (PL),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .data_in_data   (data_in_data),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out_data  (data_out_data),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out_tlast (data_out_tlast),
        .dma_done       (dma_done),
        .busy           (busy),
        .overflow_count (overflow_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Input acceptances feed the scoreboard; output handshakes drain it.
    always @(negedge clock) begin
        if (reset) begin
            if (stall_prev) begin
                check("hold_valid", data_out_valid, 1'b1);
                check("hold_data",  data_out_data,  held_data);
                check("hold_last",  data_out_tlast, held_last);
            end
            stall_prev = data_out_valid && !data_out_ready;
            held_data  = data_out_data;
            held_last  = data_out_tlast;

            if (data_in_valid && data_in_ready && enable) begin
                sb.push_back(data_in_data);
            end
            if (data_out_valid && data_out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", data_out_data, 32'hDEAD_BEEF);
                end else begin
                    check("out_data", data_out_data, sb.pop_front());
                    check("out_last", data_out_tlast, (out_idx == PL - 1));
                    out_idx = (out_idx + 1) % PL;
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_n(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            data_in_valid = 1'b1;
            data_in_data  = first + DW'(i);
        end
        @(posedge clock); #1;
        data_in_valid = 1'b0;
    endtask

    task automatic dma_pulse();
        @(posedge clock); #1;
        dma_done = 1'b1;
        @(posedge clock); #1;
        dma_done = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clock);
        while (!data_out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check(tag, data_out_valid, 1'b1);
    endtask

    // Called at a negedge; counts cycles until the tlast handshake is pending.
    task automatic wait_tlast(output int n);
        n = 1;
        while (!(data_out_valid && data_out_ready && data_out_tlast) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("tlast_seen", data_out_valid && data_out_ready && data_out_tlast, 1'b1);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clock);
        check("rst_in_ready", data_in_ready, 1'b0);
        @(posedge clock);
        @(negedge clock);
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_tlast", data_out_tlast, 1'b0);
        check("rst_data",  data_out_data,  '0);
        check("rst_busy",  busy,           1'b0);
        check("rst_ovf",   overflow_count, '0);
        @(posedge clock); #1;
        reset          = 1'b1;
        enable         = 1'b1;
        data_out_ready = 1'b1;

        // Packet 1: latency, throughput and framing
        push_n(1, PL);
        @(negedge clock);
        check("lat0_valid", data_out_valid, 1'b0);
        check("lat0_busy",  busy,           1'b0);
        @(negedge clock);
        check("lat1_valid", data_out_valid, 1'b0);
        check("lat1_busy",  busy,           1'b1);
        @(negedge clock);
        check("lat2_valid", data_out_valid, 1'b1);
        wait_tlast(pkt_len);
        check("pkt1_len", pkt_len, PL);
        @(negedge clock);
        check("wait_busy",  busy,           1'b1);
        check("wait_valid", data_out_valid, 1'b0);

        // No dma_done: buffer fills, no second packet, then drops
        push_n(9, FD);
        repeat (5) @(negedge clock);
        check("no_pkt2_valid", data_out_valid, 1'b0);
        check("no_pkt2_busy",  busy,           1'b1);
        push_n(25, 5);
        @(negedge clock);
        check("full_ready", data_in_ready,  1'b0);
        check("ovf_count",  overflow_count, EXP_OVF);

        @(posedge clock); #1;
        enable = 1'b0;
        @(negedge clock);
        check("dis_full_ready", data_in_ready, 1'b1);
        push_n(40, 3);
        @(negedge clock);
        check("dis_ovf", overflow_count, EXP_OVF);
        @(posedge clock); #1;
        enable = 1'b1;

        // dma_done releases packet 2 after a 2-cycle gap, with a stall inside
        dma_pulse();
        @(negedge clock);
        check("gap0_busy",  busy,           1'b0);
        check("gap0_valid", data_out_valid, 1'b0);
        @(negedge clock);
        check("gap1_busy",  busy,           1'b1);
        check("gap1_valid", data_out_valid, 1'b0);
        @(negedge clock);
        check("gap2_valid", data_out_valid, 1'b1);
        @(posedge clock); #1;
        data_out_ready = 1'b0;
        @(posedge clock); #1;
        data_out_ready = 1'b0;
        @(posedge clock); #1;
        data_out_ready = 1'b1;
        @(negedge clock);
        wait_tlast(pkt_len);
        dma_pulse();
        wait_valid("pkt3_valid");
        wait_tlast(pkt_len);
        check("pkt3_len", pkt_len, PL);
        dma_pulse();

        // Reset in the middle of a packet
        push_n(100, PL);
        wait_valid("pkt4_valid");
        for (int i = 0; i < 20 && out_idx < 4; i++) begin
            @(negedge clock);
        end
        check("pkt4_midway", out_idx >= 4, 1'b1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_in_ready", data_in_ready, 1'b0);
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_valid", data_out_valid, 1'b0);
        check("mid_rst_tlast", data_out_tlast, 1'b0);
        check("mid_rst_data",  data_out_data,  '0);
        check("mid_rst_busy",  busy,           1'b0);
        check("mid_rst_ovf",   overflow_count, '0);
        sb.delete();
        out_idx = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        push_n(200, PL);
        wait_valid("pkt5_valid");
        wait_tlast(pkt_len);
        check("pkt5_len", pkt_len, PL);
        dma_pulse();

        // Capture disabled: samples are ignored
        @(posedge clock); #1;
        enable = 1'b0;
        push_n(500, 20);
        @(negedge clock);
        check("dis_ready", data_in_ready, 1'b1);
        repeat (5) @(negedge clock);
        check("dis_valid", data_out_valid, 1'b0);
        check("dis_busy",  busy,           1'b0);
        check("dis_ovf0",  overflow_count, '0);
        @(posedge clock); #1;
        enable = 1'b1;
        push_n(300, PL);
        wait_valid("pkt6_valid");
        wait_tlast(pkt_len);
        check("pkt6_len", pkt_len, PL);
        dma_pulse();

        @(negedge clock);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scope_dma_packetizer.md
# scope_dma_packetizer

Buffers the scope sample stream and cuts it into fixed-length DMA packets for the PS scope stream port. Each packet carries `tlast` on its final word. After each packet the block holds off until the PS reports `dma_done`, so the DMA is re-armed before the next packet starts. It sits directly upstream of the Zynq PS wrapper's `scope` stream input, and samples arriving while the buffer is full are dropped and counted.

## Interface
- `DATA_WIDTH`, 32: sample/word width.
- `PACKET_LENGTH`, 1024: words per DMA packet; ≥ 2.
- `FIFO_DEPTH`, 2048: buffer depth in words; power of two, ≥ `PACKET_LENGTH`.

Ports:
- `clock`  in  1  single block clock (logic clock).
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  capture enable.
- `data_in`  axi_stream.slave  `DATA_WIDTH`  sample stream (`data`, `valid`, `ready`).
- `data_out`  axi_stream.master  `DATA_WIDTH`  packet stream to PS `scope` (`data`, `valid`, `ready`, `tlast`).
- `dma_done`  in  1  single-cycle DMA completion pulse from PS.
- `busy`  out  1  high in SEND or WAIT_DMA.
- `overflow_count`  out  32  dropped-sample count.

## Operation
- Write side:
  - `data_in.ready` = 1 when `enable`=0; samples are discarded and not counted.
  - When `enable`=1, `data_in.ready` = !full.
  - valid & ready & enable: word written to FIFO.
  - valid & full & enable: sample dropped; `overflow_count` +1, saturating at 2^32−1.
- FIFO occupancy `count` ranges 0..`FIFO_DEPTH`. Read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
- A simultaneous read and write leaves `count` unchanged. `ready` is computed from the pre-read count, so a slot freed by a read is usable the next cycle.
- FSM:
  - IDLE → SEND when `count` ≥ `PACKET_LENGTH`; word counter cleared.
  - SEND: words are popped into the registered output stage. `data_out.valid` stays high across the packet while the FIFO supplies words. `tlast` = 1 only on word `PACKET_LENGTH`−1. After the `tlast` handshake → WAIT_DMA.
  - WAIT_DMA → IDLE on `dma_done`=1. `dma_done` is ignored in IDLE and SEND.
- The FIFO keeps accepting input in all states, including during SEND and WAIT_DMA.
- Output rules:
  - While `valid`=1 and `ready`=0, `data_out.data` and `tlast` are held stable.
  - `valid` is never withdrawn before its handshake.
- `enable` falling mid-packet does not abort the packet; the packet completes from buffered data.

## Timing
- Reset (`reset`=0 at a `clock` edge), next cycle:
  - `data_out.valid`=0, `tlast`=0, `data`=0.
  - `busy`=0, `overflow_count`=0.
  - FIFO emptied, FSM in IDLE.
  - `data_in.ready`=0 during reset.
- Reset mid-packet aborts the packet with no `tlast`; the partial packet is lost.
- Latency: with `data_out.ready`=1, the first `data_out.valid` rises 2 cycles after the handshake of the `PACKET_LENGTH`-th buffered word (1 cycle count update/FSM, 1 cycle output register).
- Throughput in SEND with `ready` held high: one word per cycle. A packet takes exactly `PACKET_LENGTH` cycles from first `valid` to `tlast` handshake.
- `busy` rises the cycle the FSM enters SEND and falls the cycle after `dma_done` is sampled in WAIT_DMA.
- Minimum gap between packets: 2 cycles after `dma_done` (IDLE evaluation plus output register).

## Configuration
- `SCOPE_OVERFLOW_COUNT_EN`:
  - Defined: overflow counter implemented as above.
  - Undefined: the counter is not synthesized and `overflow_count` is tied to 0. Drop behaviour is unchanged.

## Test plan
- `PACKET_LENGTH`=8, `FIFO_DEPTH`=16, `ready`=1, 8 samples 1..8 → `data_out` 1..8 on consecutive cycles, `tlast` only with 8, first `valid` 2 cycles after sample 8; `busy`=1 until `dma_done`.
- No `dma_done` after packet 1, 16 more samples pushed → no second packet. Then `dma_done` pulse → second packet starts 2 cycles later, data 9..16.
- FIFO full (16 words buffered, WAIT_DMA), 5 more valid samples → `ready`=0, `overflow_count`=5. With the macro undefined → `overflow_count`=0.
- `data_out.ready` toggled 1,0,0,1 during SEND → `data` and `tlast` stable while stalled; no word lost or duplicated.
- `reset`=0 asserted at word 4 of a packet → next cycle all outputs 0 and FIFO empty; after release, 8 fresh samples produce a clean packet.
- `enable`=0 with 20 valid samples → `ready`=1, nothing buffered, no packet, `overflow_count`=0.
